aes_mem_streamer: RTL and testbench

- Engine-side master for the AES block memory. It reads plaintext words from the input region of the memory's engine port and packs them into 128-bit blocks for the AES core.
- It writes the 128-bit results back into the output region, then appends the 32'hDEADBEEF terminator.
- It sits between the memory's engine port (10-bit address, 4-bit byte write enable, 32-bit data) and the AES core's valid/ready block interface. A CPU-visible start/done pair controls it.

---
 rtl/aes_mem_streamer.sv | 199 +++++++++++++++++++
 tb/tb_aes_mem_streamer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_mem_streamer.sv
`default_nettype none
// ============================================================================
// Module   : aes_mem_streamer
// Brief    : Streams plaintext words from block memory through an AES core
//            and writes results back, closed by a terminator word.
// Revision : 1.0
// ============================================================================
module aes_mem_streamer #(
  parameter int          IN_BASE      = 0,
  parameter int          OUT_BASE     = 257,
  parameter int          MAX_WORDS    = 256,
  parameter logic [31:0] TERMINATOR   = 32'hDEADBEEF,
  parameter int          READ_LATENCY = 2
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         start_in,
  output logic         busy_out,
  output logic         done_out,
  output logic [6:0]   blocks_out,
  output logic [9:0]   mem_addr_out,
  output logic [3:0]   mem_we_out,
  output logic [31:0]  mem_wdata_out,
  input  logic [31:0]  mem_rdata_in,
  output logic [127:0] blk_data_out,
  output logic         blk_valid_out,
  input  logic         blk_ready_in,
  input  logic [127:0] res_data_in,
  input  logic         res_valid_in,
  output logic         res_ready_out
);

  localparam int               IDX_W      = $clog2(MAX_WORDS + 1);
  localparam logic [IDX_W-1:0] c_MAX_IDX  = IDX_W'(MAX_WORDS);
  localparam logic [3:0]       c_LAT_LAST = 4'(READ_LATENCY - 1);
  localparam logic [9:0]       c_IN_BASE  = 10'(IN_BASE);
  localparam logic [9:0]       c_OUT_BASE = 10'(OUT_BASE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_SEND  = 3'd3,
    S_RECV  = 3'd4,
    S_WRITE = 3'd5,
    S_TERM  = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_idx;
  logic [3:0]         r_lat;
  logic [0:3][31:0]   r_lane;
  logic               r_last;
  logic [127:0]       r_res;
  logic [1:0]         r_wcnt;
  logic [6:0]         r_blk;
  logic [6:0]         r_blocks;

  logic               w_sample;
  logic               w_is_term;
  logic [1:0]         w_lane;
  logic [IDX_W-1:0]   w_idx_inc;
  logic [9:0]         w_rd_addr;
  logic [9:0]         w_wr_addr;

  assign w_sample  = (r_state == S_WAIT) && (r_lat == c_LAT_LAST);
  assign w_is_term = (mem_rdata_in == TERMINATOR);
  assign w_lane    = r_idx[1:0];
  assign w_idx_inc = r_idx + 1'b1;
  assign w_rd_addr = c_IN_BASE + 10'(r_idx);
  // {blk, j} is exactly 4*blk + j.
  assign w_wr_addr = c_OUT_BASE + {1'b0, r_blk, r_wcnt};

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    busy_out      = (r_state != S_IDLE);
    done_out      = 1'b0;
    mem_addr_out  = '0;
    mem_we_out    = '0;
    mem_wdata_out = '0;
    blk_valid_out = 1'b0;
    res_ready_out = 1'b0;
    case (r_state)
      S_IDLE: if (start_in) w_next = S_FETCH;
      S_FETCH: begin
        mem_addr_out = w_rd_addr;
        w_next       = S_WAIT;
      end
      S_WAIT: begin
        mem_addr_out = w_rd_addr;
        if (w_sample) begin
          if (w_is_term)            w_next = (w_lane == 2'd0) ? S_TERM : S_SEND;
          else if (w_lane == 2'd3)  w_next = S_SEND;
          else                      w_next = S_FETCH;
        end
      end
      S_SEND: begin
        blk_valid_out = 1'b1;
        if (blk_ready_in) w_next = S_RECV;
      end
      S_RECV: begin
        res_ready_out = 1'b1;
        if (res_valid_in) w_next = S_WRITE;
      end
      S_WRITE: begin
        mem_addr_out = w_wr_addr;
        mem_we_out   = 4'hF;
        case (r_wcnt)
          2'd0:    mem_wdata_out = r_res[127:96];
          2'd1:    mem_wdata_out = r_res[95:64];
          2'd2:    mem_wdata_out = r_res[63:32];
          default: mem_wdata_out = r_res[31:0];
        endcase
        if (r_wcnt == 2'd3) w_next = r_last ? S_TERM : S_FETCH;
      end
      S_TERM: begin
        mem_addr_out  = c_OUT_BASE + {1'b0, r_blk, 2'b00};
        mem_we_out    = 4'hF;
        mem_wdata_out = TERMINATOR;
        w_next        = S_DONE;
      end
      S_DONE: begin
        done_out = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_idx    <= '0;
      r_lat    <= '0;
      r_lane   <= '0;
      r_last   <= 1'b0;
      r_res    <= '0;
      r_wcnt   <= '0;
      r_blk    <= '0;
      r_blocks <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_idx    <= '0;
            r_blk    <= '0;
            r_blocks <= '0;
            r_last   <= 1'b0;
            r_lane   <= '0;
          end
        end
        S_FETCH: r_lat <= '0;
        S_WAIT: begin
          if (!w_sample) begin
            r_lat <= r_lat + 1'b1;
          end else if (w_is_term) begin
            // A partial block is padded with zeros and becomes the final one.
            if (w_lane != 2'd0) begin
              for (int k = 0; k < 4; k++) begin
                if (2'(k) >= w_lane) r_lane[k] <= '0;
              end
              r_last <= 1'b1;
            end
          end else begin
            r_lane[w_lane] <= mem_rdata_in;
            r_idx          <= w_idx_inc;
            if ((w_lane == 2'd3) && (w_idx_inc == c_MAX_IDX)) r_last <= 1'b1;
          end
        end
        S_RECV: begin
          if (res_valid_in) begin
            r_res  <= res_data_in;
            r_wcnt <= '0;
          end
        end
        S_WRITE: begin
          r_wcnt <= r_wcnt + 1'b1;
          if (r_wcnt == 2'd3) begin
            r_blk <= r_blk + 1'b1;
            if (!r_last) r_lane <= '0;
          end
        end
        S_TERM: r_blocks <= r_blk;
        default: ;
      endcase
    end
  end

  assign blk_data_out = r_lane;
  assign blocks_out   = r_blocks;

endmodule
`default_nettype wire

// File: tb/tb_aes_mem_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_mem_streamer
// Brief    : Directed self-checking bench with memory and AES core models.
// Revision : 1.0
// ============================================================================
module tb_aes_mem_streamer;

  localparam logic [31:0] c_TERM   = 32'hDEADBEEF;
  localparam logic [31:0] c_POISON = 32'h0BAD0BAD;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b1;
  logic         start_in = 1'b0;
  logic         busy_out;
  logic         done_out;
  logic [6:0]   blocks_out;
  logic [9:0]   mem_addr_out;
  logic [3:0]   mem_we_out;
  logic [31:0]  mem_wdata_out;
  logic [31:0]  mem_rdata_in = '0;
  logic [127:0] blk_data_out;
  logic         blk_valid_out;
  logic         blk_ready_in = 1'b0;
  logic [127:0] res_data_in = '0;
  logic         res_valid_in = 1'b0;
  logic         res_ready_out;

  always #5 clk_in = ~clk_in;

  aes_mem_streamer dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .blocks_out    (blocks_out),
    .mem_addr_out  (mem_addr_out),
    .mem_we_out    (mem_we_out),
    .mem_wdata_out (mem_wdata_out),
    .mem_rdata_in  (mem_rdata_in),
    .blk_data_out  (blk_data_out),
    .blk_valid_out (blk_valid_out),
    .blk_ready_in  (blk_ready_in),
    .res_data_in   (res_data_in),
    .res_valid_in  (res_valid_in),
    .res_ready_out (res_ready_out)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] img [1024];
  logic [31:0] mem [1024];
  bit          load_req = 1'b0;
  int          ready_delay = 0;
  int          res_delay = 0;

  int n_done = 0, n_wr = 0, n_hs = 0, n_valid = 0;
  int n_stab = 0, n_rr = 0, n_early = 0, n_rd100 = 0;
  logic [9:0]   last_waddr = '0;
  logic [127:0] cap = '0;

  // Memory model: data is presented only in the exact cycle READ_LATENCY (2)
  // after a new address appears, poison otherwise. AES model returns ~block.
  bit          prev_rd = 1'b0;
  logic [9:0]  prev_addr = '0;
  logic [9:0]  rd_addr = '0;
  int          age = 7;
  int          rs = 0, vcnt = 0, rcnt = 0;
  bit          pv = 1'b0;
  logic [127:0] pdata = '0;

  always @(negedge clk_in) begin
    bit rd;
    if (load_req) for (int i = 0; i < 1024; i++) mem[i] = img[i];
    rd = busy_out && (mem_we_out == 4'h0);
    if (rd && !(prev_rd && prev_addr == mem_addr_out)) begin
      age = 0;
      rd_addr = mem_addr_out;
      if (mem_addr_out == 10'h100) n_rd100++;
    end else if (age < 7) begin
      age++;
    end
    mem_rdata_in = (age == 2) ? mem[rd_addr] : c_POISON;
    prev_rd = rd;
    prev_addr = mem_addr_out;
    if (mem_we_out != 4'h0) begin
      for (int b = 0; b < 4; b++)
        if (mem_we_out[b]) mem[mem_addr_out][8*b +: 8] = mem_wdata_out[8*b +: 8];
      n_wr++;
      last_waddr = mem_addr_out;
      if (rs == 1) n_early++;
    end
    if (done_out) n_done++;
    if (blk_valid_out) n_valid++;

    if (rst_in) begin
      rs = 0; vcnt = 0; rcnt = 0; pv = 1'b0;
      blk_ready_in = 1'b0;
      res_valid_in = 1'b0;
    end else begin
      case (rs)
        0: begin
          if (blk_valid_out) begin
            if (pv && (blk_data_out !== pdata)) n_stab++;
            pv = 1'b1;
            pdata = blk_data_out;
            if (vcnt >= ready_delay) begin
              blk_ready_in = 1'b1;
              cap = blk_data_out;
              n_hs++;
              rs = 1; pv = 1'b0; vcnt = 0; rcnt = 0;
            end else begin
              vcnt++;
            end
          end else begin
            if (pv) n_stab++;
            pv = 1'b0;
          end
        end
        1: begin
          blk_ready_in = 1'b0;
          if (!res_ready_out) n_rr++;
          if (rcnt >= res_delay) begin
            res_valid_in = 1'b1;
            res_data_in = ~cap;
            rs = 2;
          end else begin
            rcnt++;
          end
        end
        default: begin
          res_valid_in = 1'b0;
          rs = 0;
        end
      endcase
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 1024; i++) img[i] = '0;
  endtask

  task automatic load();
    load_req = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    load_req = 1'b0;
  endtask

  task automatic run(input string tag, input int bound, input logic [6:0] exp_blocks);
    bit seen;
    int d0;
    d0 = n_done;
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    check({tag, "_busy"}, 128'(busy_out), 128'(1));
    seen = 1'b0;
    for (int n = 0; n < bound && !seen; n++) begin
      @(negedge clk_in);
      if (done_out) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 128'(seen), 128'(1));
    check({tag, "_blocks_at_done"}, 128'(blocks_out), 128'(exp_blocks));
    @(negedge clk_in);
    check({tag, "_idle"}, 128'({busy_out, done_out}), 128'(0));
    check({tag, "_one_done"}, 128'(n_done - d0), 128'(1));
  endtask

  initial begin
    int w0, h0, v0, r0, s0, rr0, e0, d0;
    bit seen;

    // Reset state
    clear_img();
    load_req = 1'b1;
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    load_req = 1'b0;
    rst_in = 1'b0;
    @(negedge clk_in);
    check("rst_ctrl", 128'({busy_out, done_out, blk_valid_out, res_ready_out}), 128'(0));
    check("rst_blocks", 128'(blocks_out), 128'(0));
    check("rst_mem_if", 128'({mem_addr_out, mem_we_out, mem_wdata_out}), 128'(0));
    check("rst_blk_data", blk_data_out, 128'(0));

    // Test 1: one full block then terminator
    clear_img();
    img[0] = 32'h11111111; img[1] = 32'h22222222;
    img[2] = 32'h33333333; img[3] = 32'h44444444; img[4] = c_TERM;
    load();
    w0 = n_wr; h0 = n_hs; v0 = n_valid;
    run("t1", 200, 7'd1);
    check("t1_blk", cap, 128'h11111111_22222222_33333333_44444444);
    check("t1_out", {mem[257], mem[258], mem[259], mem[260]},
          128'hEEEEEEEE_DDDDDDDD_CCCCCCCC_BBBBBBBB);
    check("t1_term", 128'(mem[261]), 128'(c_TERM));
    check("t1_writes", 128'(n_wr - w0), 128'(5));
    check("t1_last_waddr", 128'(last_waddr), 128'(261));
    check("t1_hs", 128'(n_hs - h0), 128'(1));
    check("t1_valid_cycles", 128'(n_valid - v0), 128'(1));

    // Test 2: empty input
    clear_img();
    img[0] = c_TERM;
    load();
    w0 = n_wr; h0 = n_hs; v0 = n_valid;
    run("t2", 100, 7'd0);
    check("t2_valid_cycles", 128'(n_valid - v0), 128'(0));
    check("t2_writes", 128'(n_wr - w0), 128'(1));
    check("t2_term", 128'(mem[257]), 128'(c_TERM));
    check("t2_last_waddr", 128'(last_waddr), 128'(257));

    // Test 3: partial block zero-filled
    clear_img();
    img[0] = 32'hAAAA0001; img[1] = 32'hAAAA0002; img[2] = c_TERM;
    load();
    run("t3", 200, 7'd1);
    check("t3_blk", cap, 128'hAAAA0001_AAAA0002_00000000_00000000);
    check("t3_out", {mem[257], mem[258], mem[259], mem[260]},
          128'h5555FFFE_5555FFFD_FFFFFFFF_FFFFFFFF);
    check("t3_term", 128'(mem[261]), 128'(c_TERM));

    // Test 4: full input region, no terminator read
    clear_img();
    for (int i = 0; i < 256; i++) img[i] = 32'h10000000 + 32'(i);
    img[256] = c_TERM;
    load();
    h0 = n_hs; r0 = n_rd100; w0 = n_wr;
    run("t4", 5000, 7'd64);
    check("t4_hs", 128'(n_hs - h0), 128'(64));
    check("t4_first", 128'(mem[257]), 128'(32'hEFFFFFFF));
    check("t4_last_data", 128'(mem[512]), 128'(32'hEFFFFF00));
    check("t4_term", 128'(mem[513]), 128'(c_TERM));
    check("t4_last_waddr", 128'(last_waddr), 128'(513));
    check("t4_writes", 128'(n_wr - w0), 128'(257));
    check("t4_no_rd_0x100", 128'(n_rd100 - r0), 128'(0));

    // Test 5: backpressure on both handshakes
    clear_img();
    img[0] = 32'h11111111; img[1] = 32'h22222222;
    img[2] = 32'h33333333; img[3] = 32'h44444444; img[4] = c_TERM;
    load();
    ready_delay = 10; res_delay = 7;
    v0 = n_valid; s0 = n_stab; rr0 = n_rr; e0 = n_early;
    run("t5", 300, 7'd1);
    check("t5_valid_cycles", 128'(n_valid - v0), 128'(11));
    check("t5_stable", 128'(n_stab - s0), 128'(0));
    check("t5_res_ready", 128'(n_rr - rr0), 128'(0));
    check("t5_no_early_wr", 128'(n_early - e0), 128'(0));
    check("t5_out", {mem[257], mem[258], mem[259], mem[260]},
          128'hEEEEEEEE_DDDDDDDD_CCCCCCCC_BBBBBBBB);
    check("t5_term", 128'(mem[261]), 128'(c_TERM));
    ready_delay = 0; res_delay = 0;

    // Test 6: reset during WRITE j=1, then a clean run
    clear_img();
    img[0] = 32'h11111111; img[1] = 32'h22222222;
    img[2] = 32'h33333333; img[3] = 32'h44444444; img[4] = c_TERM;
    load();
    d0 = n_done;
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk_in);
      if (mem_we_out != 4'h0) seen = 1'b1;
    end
    check("t6_write_seen", 128'(seen), 128'(1));
    @(negedge clk_in);
    check("t6_j1", 128'({mem_addr_out, mem_we_out}), 128'({10'd258, 4'hF}));
    rst_in = 1'b1;
    @(negedge clk_in);
    check("t6_rst_we", 128'(mem_we_out), 128'(0));
    check("t6_rst_busy", 128'({busy_out, blk_valid_out, res_ready_out}), 128'(0));
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("t6_no_done", 128'(n_done - d0), 128'(0));
    clear_img();
    img[0] = 32'hAAAA0001; img[1] = 32'hAAAA0002; img[2] = c_TERM;
    load();
    run("t6b", 200, 7'd1);
    check("t6b_out", {mem[257], mem[258], mem[259], mem[260]},
          128'h5555FFFE_5555FFFD_FFFFFFFF_FFFFFFFF);
    check("t6b_term", 128'(mem[261]), 128'(c_TERM));
    repeat (2) @(negedge clk_in);
    check("t6b_blocks_hold", 128'(blocks_out), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
